// File: rtl/signed_seq_divider_pkg.sv
// Shared types and constants for the signed sequential divider.
package signed_seq_divider_pkg;

  // Default operand width; the dividend is twice this wide.
  localparam int DIV_WIDTH = 16;

  // Iteration counter width for the default operand width.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  // Counter width for an arbitrary operand width (at least one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/signed_seq_divider_if.sv
// Start/done handshake and operand/result bus of the signed divider.
interface signed_seq_divider_if #(
  parameter int WIDTH = signed_seq_divider_pkg::DIV_WIDTH
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 dbz;
  logic                 ovf;
  logic                 busy;
  logic                 done;

  // Requester side: issues operands, observes results.
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, dbz, ovf, busy, done
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, dbz, ovf, busy, done
  );
endinterface

// File: rtl/signed_seq_divider_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs_mag,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {2'b00, dvs_mag};
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end
endmodule

// File: rtl/signed_seq_divider.sv
// Iterative signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, fixed latency of WIDTH+2 cycles.
module signed_seq_divider
  import signed_seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  signed_seq_divider_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] NEG_LIMIT = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH:0]     rem_reg;      // partial remainder
  logic [WIDTH-1:0]   lo_reg;       // low dividend bits out, quotient bits in
  logic [WIDTH-1:0]   dvs_mag_reg;
  logic               dvd_neg_reg;
  logic               dvs_neg_reg;
  logic               pre_dbz_reg;
  logic               pre_ovf_reg;
  logic [WIDTH-1:0]   quotient_reg;
  logic [WIDTH-1:0]   remainder_reg;
  logic               dbz_reg;
  logic               ovf_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;
  logic               pre_dbz;
  logic               pre_ovf;
  logic [WIDTH:0]     step_rem;
  logic               step_q;
  logic               q_neg;
  logic [WIDTH-1:0]   q_signed;
  logic [WIDTH-1:0]   r_signed;
  logic               range_bad;

  // Operand magnitudes and early error detection on the live inputs.
  // If the upper dividend half already reaches the divisor the quotient
  // cannot fit in WIDTH bits, so the restoring loop result is discarded.
  always_comb begin
    dvd_mag = bus.dividend[2*WIDTH-1] ? -bus.dividend : bus.dividend;
    dvs_mag = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    pre_dbz = (bus.divisor == '0);
    pre_ovf = !pre_dbz && (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag);
  end

  // Single restoring stage reused on every RUN cycle.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (lo_reg[WIDTH-1]),
    .dvs_mag (dvs_mag_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Sign correction and signed range check of the finished magnitudes.
  always_comb begin
    q_neg     = dvd_neg_reg ^ dvs_neg_reg;
    q_signed  = q_neg ? -lo_reg : lo_reg;
    r_signed  = dvd_neg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
    range_bad = q_neg ? (lo_reg > NEG_LIMIT) : lo_reg[WIDTH-1];
  end

  // Control FSM with registered results, flags and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      lo_reg        <= '0;
      dvs_mag_reg   <= '0;
      dvd_neg_reg   <= 1'b0;
      dvs_neg_reg   <= 1'b0;
      pre_dbz_reg   <= 1'b0;
      pre_ovf_reg   <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            rem_reg       <= {1'b0, dvd_mag[2*WIDTH-1:WIDTH]};
            lo_reg        <= dvd_mag[WIDTH-1:0];
            dvs_mag_reg   <= dvs_mag;
            dvd_neg_reg   <= bus.dividend[2*WIDTH-1];
            dvs_neg_reg   <= bus.divisor[WIDTH-1];
            pre_dbz_reg   <= pre_dbz;
            pre_ovf_reg   <= pre_ovf;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            busy_reg      <= 1'b1;
            cnt_reg       <= CNT_W'(WIDTH - 1);
            state_reg     <= ST_RUN;
          end
        end
        ST_RUN: begin
          rem_reg <= step_rem;
          lo_reg  <= {lo_reg[WIDTH-2:0], step_q};
          if (cnt_reg == '0) begin
            state_reg <= ST_FIX;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_FIX: begin
          // rem_reg[WIDTH] can only be set when the pre-check already failed.
          if (pre_dbz_reg) begin
            dbz_reg       <= 1'b1;
            quotient_reg  <= '0;
            remainder_reg <= '0;
          end else if (pre_ovf_reg || range_bad || rem_reg[WIDTH]) begin
            ovf_reg       <= 1'b1;
            quotient_reg  <= '0;
            remainder_reg <= '0;
          end else begin
            quotient_reg  <= q_signed;
            remainder_reg <= r_signed;
          end
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_DONE;
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.dbz       = dbz_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
endmodule

// File: tb/tb_signed_seq_divider.sv
// Scoreboard bench for signed_seq_divider at WIDTH=16.
module tb_signed_seq_divider;
  localparam int W = 16;
  localparam int LAT = W + 1;  // edges from accept edge to done-visible edge

  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           dbz;
    logic           ovf;
    int             acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  signed_seq_divider_if #(.WIDTH(W)) bus();

  signed_seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer division, truncating toward zero.
  function automatic exp_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, input int acc);
    exp_t   e;
    longint a;
    longint b;
    longint qq;
    longint rr;
    a = longint'($signed(dvd));
    b = longint'($signed(dvs));
    e.dvd = dvd; e.dvs = dvs; e.acc = acc;
    e.q = '0; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b0;
    if (b == 0) begin
      e.dbz = 1'b1;
    end else begin
      qq = a / b;
      rr = a % b;
      if (qq > 32767 || qq < -32768) e.ovf = 1'b1;
      else begin
        e.q = qq[W-1:0];
        e.r = rr[W-1:0];
      end
    end
    return e;
  endfunction

  // Result monitor: pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    exp_t   e;
    longint a, b, qd, rd;
    if (rst_n && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] %h / %h -> q=%h r=%h dbz=%b ovf=%b lat=%0d",
                 e.dvd, e.dvs, bus.quotient, bus.remainder, bus.dbz, bus.ovf, cyc - e.acc);
        chk("quotient", bus.quotient, e.q);
        chk("remainder", bus.remainder, e.r);
        chk("dbz", bus.dbz, e.dbz);
        chk("ovf", bus.ovf, e.ovf);
        chk("latency", cyc - e.acc, LAT);
        chk("busy_at_done", bus.busy, 0);
        if (!bus.dbz && !bus.ovf) begin
          a  = longint'($signed(e.dvd));
          b  = longint'($signed(e.dvs));
          qd = longint'($signed(bus.quotient));
          rd = longint'($signed(bus.remainder));
          chk("invariant", qd * b + rd, a);
          chk("rem_bound", ((rd < 0 ? -rd : rd) < (b < 0 ? -b : b)) ? 1 : 0, 1);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("idle_timeout", 0, 1);
  endtask

  // Drive one request; returns the edge number at which it was accepted.
  task automatic launch(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, output int acc);
    @(posedge clk); #1;
    wait_idle();
    bus.start = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
    exp_q.push_back(model(dvd, dvs, cyc + 1));
    @(posedge clk); #1;
    acc = cyc;
    bus.start = 1'b0;
    bus.dividend = $urandom; bus.divisor = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() > 0 && n < 80) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 80) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
    int acc;
    launch(dvd, dvs, acc);
    wait_done();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    int acc, bh, dh;
    logic [2*W-1:0] dvd_tab[9];
    logic [W-1:0]   dvs_tab[9];
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #1 rst_n = 1'b0;
    #10;
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_dbz", bus.dbz, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic operation with busy/done timing.
    launch(32'd100, 16'd7, acc);
    bh = 0; dh = 0;
    for (int k = 1; k <= LAT; k++) begin
      if (bus.busy === 1'b1) bh++;
      if (bus.done === 1'b1) dh++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", bh, LAT);
    chk("early_done", dh, 0);
    chk("done_cycle", bus.done, 1);
    chk("basic_q", bus.quotient, 14);
    chk("basic_r", bus.remainder, 2);
    wait_done();

    // Sign and error cases.
    dvd_tab = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'd5, 32'h00010000,
                32'h00008000, 32'hFFFF8000, 32'hFFFF8000, 32'h7FFFFFFF};
    dvs_tab = '{16'd7, 16'hFFF9, 16'hFFF9, 16'd0, 16'd1,
                16'd1, 16'd1, 16'hFFFF, 16'h8000};
    for (int i = 0; i < 9; i++) run_op(dvd_tab[i], dvs_tab[i]);
    run_op(32'hFFFF8000, 16'd1);
    chk("minneg_q", bus.quotient, 16'h8000);
    chk("minneg_ovf", bus.ovf, 0);

    // Requests while busy or during done are dropped.
    launch(32'd100, 16'd7, acc);
    while (cyc < acc + 2) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.dividend = 32'd999; bus.divisor = 16'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    while (cyc < acc + LAT) begin @(posedge clk); #1; end
    chk("hs_done", bus.done, 1);
    bus.start = 1'b1; bus.dividend = 32'd555; bus.divisor = 16'd5;
    @(posedge clk); #1 bus.start = 1'b0;
    idle_cycles(25);
    chk("hs_q_hold", bus.quotient, 14);
    chk("hs_r_hold", bus.remainder, 2);
    chk("hs_idle", bus.busy, 0);

    // start held high: re-accept the cycle after done.
    wait_idle();
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 16'hFFF7;
    exp_q.push_back(model(32'd1000, 16'hFFF7, cyc + 1));
    @(posedge clk); #1;
    acc = cyc;
    bus.dividend = 32'hFFFFEC78; bus.divisor = 16'd13;
    exp_q.push_back(model(32'hFFFFEC78, 16'd13, acc + LAT + 2));
    while (cyc < acc + LAT + 2) begin @(posedge clk); #1; end
    bus.start = 1'b0;
    wait_done();

    // Asynchronous reset mid-operation.
    launch(32'd12345, 16'd11, acc);
    while (cyc < acc + 8) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_dbz", bus.dbz, 0);
    chk("abort_ovf", bus.ovf, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    exp_q.delete();
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(25);
    run_op(32'hFFFF8AD0, 16'd123);

    // Round trip on products.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b;
      longint p;
      logic [2*W-1:0] pd;
      a = W'($urandom);
      do b = W'($urandom); while (b == '0);
      p = longint'($signed(a)) * longint'($signed(b));
      pd = p[2*W-1:0];
      run_op(pd, b);
      chk("rt_q", bus.quotient, a);
      chk("rt_r", bus.remainder, 0);
    end

    // Arbitrary pairs, including zero divisors.
    for (int i = 0; i < 200; i++) begin
      longint v;
      logic [2*W-1:0] d;
      logic [W-1:0] s;
      v = longint'($signed($urandom)) >>> $urandom_range(0, 24);
      d = v[2*W-1:0];
      s = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom >> $urandom_range(0, 14));
      run_op(d, s);
    end

    idle_cycles(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/signed_seq_divider.md
# signed_seq_divider

Iterative signed two's-complement divider, the inverse of the team's Baugh-Wooley array multiplier. It divides a 2*WIDTH-bit dividend (a multiplier product) by a WIDTH-bit divisor, returning a WIDTH-bit quotient and remainder. A radix-2 restoring datapath resolves one quotient bit per clock behind a start/done handshake, and every accepted operation has a fixed latency. It sits beside the multiplier in the arithmetic unit so that a product can be fed straight back for checking or for scaling.

## Interface
- WIDTH, 16: operand width; dividend is 2*WIDTH bits. Legal values are 4 and up.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- dividend  in  2*WIDTH  signed dividend; sampled on accept.
- divisor  in  WIDTH  signed divisor; sampled on accept.
- quotient  out  WIDTH  signed quotient, truncated toward zero.
- remainder  out  WIDTH  signed remainder; its sign matches the dividend.
- dbz  out  1  divide-by-zero flag for the last operation.
- ovf  out  1  quotient-overflow flag for the last operation.
- busy  out  1  high from the accept cycle until done.
- done  out  1  one-cycle pulse; results are valid from this cycle.

## Operation
- **Reset values:** quotient=0, remainder=0, dbz=0, ovf=0, busy=0, done=0, FSM in IDLE.
- **States:** IDLE, RUN, FIX, DONE.
- **IDLE**
  - start=1 means accept.
  - Latch |dividend| (2*WIDTH bits), |divisor|, and both sign bits.
  - Clear quotient, remainder, dbz and ovf to 0.
  - Set busy=1 and the iteration counter to WIDTH-1, then go to RUN.
- **Pre-check, computed at accept:**
  - pre_dbz = (divisor==0).
  - pre_ovf = (|dividend| >> WIDTH) >= |divisor|, evaluated only when the divisor is non-zero.
- **RUN:** one restoring step per cycle.
  - Shift the partial remainder (WIDTH+1 bits) left, bringing in the next dividend bit.
  - Trial-subtract |divisor|. If the result is non-negative, keep it and the quotient bit is 1; otherwise restore and the quotient bit is 0.
  - When the counter reaches 0, go to FIX.
- **FIX**
  - Apply signs: quotient is negated if the operand signs differ; remainder is negated if the dividend is negative.
  - Range check: a positive quotient magnitude above 2^(WIDTH-1)-1, or a negative one above 2^(WIDTH-1), sets ovf.
  - If pre_dbz, set dbz=1 and force quotient=0, remainder=0.
  - Else, if pre_ovf or the range check fails, set ovf=1 and force quotient=0, remainder=0.
  - Otherwise register the corrected results. Go to DONE.
- **DONE:** done=1 for one cycle, busy=0, return to IDLE.
- Results and flags hold until the next accept.
- dbz and ovf are never both 1; dbz takes priority.
- Required invariant when dbz=ovf=0: dividend == quotient*divisor + remainder, with |remainder| < |divisor|.

## Timing
- An accept in cycle 0 gives RUN in cycles 1..WIDTH, FIX in cycle WIDTH+1, and done=1 in cycle WIDTH+2.
- Latency is fixed at WIDTH+2 cycles for every accepted operation, including dbz and ovf.
- start while busy=1 is ignored and does not queue.
- start asserted during DONE is ignored. The earliest next accept is the cycle after done.
- Back-to-back throughput is one operation per WIDTH+3 cycles.
- start held high continuously re-accepts in the cycle after each done.
- Reset asserted mid-operation asynchronously returns all outputs to their reset values. No done pulse is produced for the aborted operation.
- Operand inputs may change freely while busy=1; only the values latched at accept matter.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE, RUN, FIX, DONE);
  - the WIDTH default;
  - the counter width, $clog2(WIDTH).
- One natural sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial remainder, incoming dividend bit, divisor magnitude.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once and reused across RUN cycles.
- Magnitude/negate logic and the FSM live in signed_seq_divider.

## Test plan
All cases use WIDTH=16.
- **Basic:** 100 / 7 -> quotient=14, remainder=2, done exactly 18 cycles after accept, busy high for cycles 0..17.
- **Signs:**
  - -100 (0xFFFFFF9C) / 7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2).
  - 100 / -7 -> quotient=0xFFF2, remainder=2.
  - -100 / -7 -> quotient=14, remainder=0xFFFE.
- **Errors:**
  - 5 / 0 -> dbz=1, ovf=0, quotient=remainder=0, done at cycle 18.
  - 0x00010000 / 1 -> ovf=1.
  - 0x00008000 / 1 -> ovf=1.
  - 0xFFFF8000 / 1 -> quotient=0x8000, ovf=0.
  - 0xFFFF8000 / 0xFFFF -> ovf=1.
- **Handshake:**
  - Pulse start again at cycles 3 and 18 with new operands -> both ignored; first results unchanged.
  - start held high -> second accept at cycle 19, second done at cycle 37.
- **Reset:** deassert rst_n at cycle 9 of an operation -> all outputs 0 immediately, no done pulse. A new operation after release completes normally.
- **Round-trip:** 1000 random signed pairs (a, b≠0), dividend = a*b sign-extended to 32 bits -> quotient=a, remainder=0. Random (dividend, divisor) pairs must satisfy the quotient/remainder invariant whenever no flag is set.
